// File: rtl/acoustic_path_sim.sv
// acoustic_path_sim: multi-tap delayed/scaled ambient path summed with speaker into a saturated feedback-mic sample
module acoustic_path_sim #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int NUM_TAPS = 2,
  parameter int SCALE_W = 8,
  parameter int SHIFT = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                         clk_in,
  input  logic                         reset_in,
  input  logic                         ready_in,
  input  logic signed [WIDTH-1:0]      ambient_sample_in,
  input  logic signed [WIDTH-1:0]      speaker_output_in,
  input  logic [NUM_TAPS*ADDR_W-1:0]   tap_delay_in,
  input  logic [NUM_TAPS*SCALE_W-1:0]  tap_scale_in,
  output logic signed [WIDTH-1:0]      feedback_sample_out,
  output logic                         done_out,
  output logic                         busy_out,
  output logic                         overrun_out
);
  localparam int AW = WIDTH + SCALE_W + $clog2(NUM_TAPS) + 2;
  localparam int PW = WIDTH + SCALE_W + 1;
  localparam int KW = NUM_TAPS > 1 ? $clog2(NUM_TAPS) : 1;
  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
  state_t                       state_q;
  logic signed [WIDTH-1:0]      mem_q [DEPTH];
  logic [ADDR_W-1:0]            wr_ptr_q;
  logic [ADDR_W:0]              fill_q;
  logic [KW-1:0]                k_q;
  logic signed [AW-1:0]         acc_q;
  logic signed [WIDTH-1:0]      spk_q, fb_q;
  logic [NUM_TAPS*ADDR_W-1:0]   dly_q;
  logic [NUM_TAPS*SCALE_W-1:0]  scl_q;
  logic                         done_q, ovr_q;
  logic [ADDR_W-1:0]            d_k, idx;
  logic [SCALE_W-1:0]           s_k;
  logic signed [PW-1:0]         prod, prod_sh;
  logic signed [AW-1:0]         contrib, sum;
  logic [WIDTH-1:0]             sat;
  logic                         fits;
  assign d_k     = dly_q[int'(k_q)*ADDR_W +: ADDR_W];
  assign s_k     = scl_q[int'(k_q)*SCALE_W +: SCALE_W];
  assign idx     = wr_ptr_q - d_k;
  assign prod    = mem_q[idx] * $signed({1'b0, s_k});
  assign prod_sh = prod >>> SHIFT;
  // taps reaching past the written history read as silence
  assign contrib = ({1'b0, d_k} <= fill_q) ? {{(AW-PW){prod_sh[PW-1]}}, prod_sh} : '0;
  assign sum     = acc_q + {{(AW-WIDTH){spk_q[WIDTH-1]}}, spk_q};
  assign fits    = (&sum[AW-1:WIDTH-1]) | ~(|sum[AW-1:WIDTH-1]);
  assign sat     = fits ? sum[WIDTH-1:0] : {sum[AW-1], {(WIDTH-1){~sum[AW-1]}}};
  assign feedback_sample_out = fb_q;
  assign done_out    = done_q;
  assign busy_out    = state_q != IDLE;
  assign overrun_out = ovr_q;
  // delay line write on acceptance; contents survive reset
  always_ff @(posedge clk_in)
    if (!reset_in && state_q == IDLE && ready_in) mem_q[wr_ptr_q] <= ambient_sample_in;
  // sample sequencing: latch config, accumulate one tap per cycle, saturate and publish
  always_ff @(posedge clk_in or posedge reset_in)
    if (reset_in) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      spk_q    <= '0;
      dly_q    <= '0;
      scl_q    <= '0;
      fb_q     <= '0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (ready_in && state_q != IDLE) ovr_q <= 1'b1;
      case (state_q)
        IDLE: if (ready_in) begin
          spk_q   <= speaker_output_in;
          dly_q   <= tap_delay_in;
          scl_q   <= tap_scale_in;
          acc_q   <= '0;
          k_q     <= '0;
          state_q <= ACC;
        end
        ACC: begin
          acc_q <= acc_q + contrib;
          k_q   <= k_q + 1'b1;
          if (k_q == KW'(NUM_TAPS - 1)) state_q <= OUT;
        end
        OUT: begin
          fb_q     <= sat;
          done_q   <= 1'b1;
          wr_ptr_q <= wr_ptr_q + 1'b1;
          fill_q   <= fill_q == (ADDR_W+1)'(DEPTH) ? fill_q : fill_q + 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: doc/acoustic_path_sim.md
# acoustic_path_sim

Parametrised multi-tap model of the physical acoustic path between the ambient mic, the speaker and the in-ear feedback mic, for simulation benches only. Each accepted ambient sample is written into a circular delay line. NUM_TAPS independently delayed and scaled copies are then summed with the current speaker sample and saturated to produce the feedback-mic sample. Delays and scales are runtime inputs, so one instance covers direct leakage plus reflections.

## Interface
- WIDTH, 16: sample width, signed two's complement.
- DEPTH, 256: delay-line length in samples; power of two, ≥ 2. ADDR_W = clog2(DEPTH).
- NUM_TAPS, 2: number of delayed/scaled paths, ≥ 1.
- SCALE_W, 8: tap scale width, unsigned.
- SHIFT, 8: right shift applied to each tap product. Scale 2^SHIFT is unity gain.

- clk_in, input, 1: sole clock; all state changes on its rising edge.
- reset_in, input, 1: asynchronous, active-high reset.
- ready_in, input, 1: sample strobe; new ambient/speaker pair is valid.
- ambient_sample_in, input, WIDTH: signed ambient-mic sample.
- speaker_output_in, input, WIDTH: signed speaker sample.
- tap_delay_in, input, NUM_TAPS*ADDR_W: tap k delay in bits [k*ADDR_W +: ADDR_W]. Range 0..DEPTH-1 samples.
- tap_scale_in, input, NUM_TAPS*SCALE_W: tap k scale in bits [k*SCALE_W +: SCALE_W].
- feedback_sample_out, output, WIDTH: signed, saturated feedback sample; held between updates.
- done_out, output, 1: one-cycle pulse when feedback_sample_out updates.
- busy_out, output, 1: high while a sample is in process (state ≠ IDLE).
- overrun_out, output, 1: sticky; set when ready_in is dropped. Cleared only by reset.

## Operation
- FSM states: IDLE, ACC, OUT.
- Reset values: state=IDLE, feedback_sample_out=0, done_out=0, busy_out=0, overrun_out=0, wr_ptr=0, fill count=0, tap counter=0, accumulator=0. Delay-line RAM is not cleared.
- **IDLE, ready_in=1:**
  - Write ambient_sample_in to buf[wr_ptr].
  - Latch speaker_output_in, tap_delay_in and tap_scale_in.
  - Clear the accumulator and go to ACC with tap counter k=0.
- **ACC**, one tap per cycle:
  - idx = (wr_ptr − d_k) mod DEPTH, wrapping naturally in ADDR_W bits.
  - Delay 0 returns the sample just written.
  - If d_k ≥ fill count after this write, the tap contributes 0 (unwritten history reads as silence).
  - Otherwise contribution = (buf[idx] × s_k) >>> SHIFT, with s_k zero-extended to signed. The shift is arithmetic and floors toward −∞.
  - Add the contribution to the accumulator. After tap NUM_TAPS−1, go to OUT.
- **OUT:**
  - sum = accumulator + latched speaker sample.
  - Saturate sum to [−2^(WIDTH−1), 2^(WIDTH−1)−1] and register it into feedback_sample_out.
  - done_out=1; wr_ptr increments mod DEPTH; fill count increments, saturating at DEPTH.
  - Return to IDLE.
- Accumulator width: WIDTH+SCALE_W+clog2(NUM_TAPS)+2 bits, so no internal overflow. Saturation happens only at the output.
- Config is latched per sample; changes to tap inputs mid-processing do not affect the current sample.
- ready_in while busy_out=1: the sample is dropped (no write, no pointer move) and overrun_out is set. Processing continues unaffected.
- Reset mid-operation: the current sample is aborted, no done_out is issued, all registers return to reset values, and history is treated as empty (fill count=0).

## Timing
- Latency is NUM_TAPS+1 edges. The edge that samples ready_in in IDLE is E0; taps accumulate on E1..E(NUM_TAPS); output and done_out register on E(NUM_TAPS+1).
- done_out is high for exactly the one cycle after E(NUM_TAPS+1).
- busy_out is high from after E0 until after E(NUM_TAPS+1).
- Minimum accepted ready_in spacing is NUM_TAPS+2 cycles. A ready_in on the cycle done_out is high is accepted.
- feedback_sample_out changes only at OUT edges and at reset.

## Test plan
- **Single path, unity compatible:** NUM_TAPS=1, d=64, s=128; impulse ambient 1000 on sample 0, zeros after, speaker 0 → output 0 for samples 0..63, 500 on sample 64, 0 after.
- **Two paths plus speaker:** d0=0/s0=256, d1=3/s1=64; ambient 400 on every sample, speaker −100 → samples 0..2 = 300; sample 3 onward = 400.
- **Saturation and floor:**
  - ambient 32767, speaker 32767, two taps d=0, s=255 → 32767.
  - ambient −32768 likewise with speaker −32768 → −32768.
  - Single tap ambient −3, s=128 → −2.
- **Wrap and history:** DEPTH=8, d=7, ramp ambient 1,2,3… → output 0 for samples 0..6. Sample n≥7 outputs (n−6)·s>>>SHIFT across ≥ 3 pointer wraps.
- **Handshake:**
  - Assert ready_in one cycle after acceptance → sample dropped, overrun_out=1 and stays high, done_out count equals accepted samples.
  - Latency measured at NUM_TAPS+1 edges.
- **Reset mid-ACC:** assert reset_in asynchronously during ACC → outputs immediately 0, no done_out. The next sample with d=0 is processed normally; d>0 taps read 0.
